// File: rtl/demux1x8_using_1x4.sv
// Registered 1-to-8 demultiplexer built from two combinational 1x4 demux halves.
// Latency: 1 clk from select/data to outputs. Backpressure: none, outputs reload every cycle.

// 1x4 demux: routes in to the output indexed by {s1,s0}; the other three are 0.
// Latency: 0 (combinational). Backpressure: none.
// Shared select lines let two instances form the lower and upper halves of a 1x8.
module demux1x4 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3
);

    always_comb begin
        y0 = '0;
        y1 = '0;
        y2 = '0;
        y3 = '0;
        unique case ({s1, s0})
            2'b00: y0 = in;
            2'b01: y1 = in;
            2'b10: y2 = in;
            2'b11: y3 = in;
            default: ;
        endcase
    end

endmodule

// 1x8 demux: s2 steers in to the lower (y0..y3) or upper (y4..y7) 1x4 half.
// Latency: 1 clk, outputs registered. Backpressure: none, no enable.
// Asynchronous active-high rst clears all outputs immediately.
module demux1x8_using_1x4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s2,
    input  logic             s1,
    input  logic             s0,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6,
    output logic [WIDTH-1:0] y7
);

    logic [WIDTH-1:0] lower_in;
    logic [WIDTH-1:0] upper_in;
    logic [WIDTH-1:0] d0, d1, d2, d3, d4, d5, d6, d7;

    // Gate the data per half so the unselected half always decodes to zero.
    assign lower_in = in & ~{WIDTH{s2}};
    assign upper_in = in &  {WIDTH{s2}};

    demux1x4 #(.WIDTH(WIDTH)) u_lower (
        .in (lower_in),
        .s1 (s1),
        .s0 (s0),
        .y0 (d0),
        .y1 (d1),
        .y2 (d2),
        .y3 (d3)
    );

    demux1x4 #(.WIDTH(WIDTH)) u_upper (
        .in (upper_in),
        .s1 (s1),
        .s0 (s0),
        .y0 (d4),
        .y1 (d5),
        .y2 (d6),
        .y3 (d7)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y0 <= '0;
            y1 <= '0;
            y2 <= '0;
            y3 <= '0;
            y4 <= '0;
            y5 <= '0;
            y6 <= '0;
            y7 <= '0;
        end else begin
            y0 <= d0;
            y1 <= d1;
            y2 <= d2;
            y3 <= d3;
            y4 <= d4;
            y5 <= d5;
            y6 <= d6;
            y7 <= d7;
        end
    end

endmodule

// File: tb/tb_demux1x8_using_1x4.sv
// Directed bench for demux1x8_using_1x4: a WIDTH=1 and a WIDTH=8 instance share clock, reset and select.
module tb_demux1x8_using_1x4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s2 = 1'b0, s1 = 1'b0, s0 = 1'b0;
    logic [0:0] in = 1'b0;
    logic [7:0] y;
    logic [7:0] w_in = 8'h00;
    logic [7:0] w_y [8];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux1x8_using_1x4 #(.WIDTH(1)) dut (
        .clk (clk), .rst (rst),
        .s2 (s2), .s1 (s1), .s0 (s0),
        .in (in),
        .y0 (y[0]), .y1 (y[1]), .y2 (y[2]), .y3 (y[3]),
        .y4 (y[4]), .y5 (y[5]), .y6 (y[6]), .y7 (y[7])
    );

    demux1x8_using_1x4 #(.WIDTH(8)) dut_w8 (
        .clk (clk), .rst (rst),
        .s2 (s2), .s1 (s1), .s0 (s0),
        .in (w_in),
        .y0 (w_y[0]), .y1 (w_y[1]), .y2 (w_y[2]), .y3 (w_y[3]),
        .y4 (w_y[4]), .y5 (w_y[5]), .y6 (w_y[6]), .y7 (w_y[7])
    );

    task automatic set_sel(input logic [2:0] sel);
        {s2, s1, s0} = sel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // y packed as {y7..y0}, one bit per output
    task automatic check_y(input string tag, input logic [7:0] exp);
        n_checks++;
        assert (y === exp) else begin
            n_fail++;
            $error("FAIL %s: observed y7..y0=%b expected %b", tag, y, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [63:0] exp);
        logic [63:0] obs;
        obs = {w_y[7], w_y[6], w_y[5], w_y[4], w_y[3], w_y[2], w_y[1], w_y[0]};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed y7..y0=%h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset asserted before any clock edge clears outputs immediately
        in = 1'b1;
        set_sel(3'b101);
        #1 rst = 1'b1;
        #1;
        check_y("reset_async", 8'h00);
        check_w("reset_async_w8", 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_y("reset_hold_until_edge", 8'h00);
        tick();
        check_y("after_reset_y5", 8'b0010_0000);

        // Exhaustive sweep: in=0 then in=1 per select value
        for (int k = 0; k < 8; k++) begin
            set_sel(k[2:0]);
            in = 1'b0;
            tick();
            check_y($sformatf("sweep_in0_sel%0d", k), 8'h00);
            in = 1'b1;
            tick();
            check_y($sformatf("sweep_in1_sel%0d", k), 8'h01 << k);
        end

        // Latency: select change is invisible until the next edge
        set_sel(3'b000);
        tick();
        check_y("lat_sel000", 8'b0000_0001);
        set_sel(3'b111);
        #2;
        check_y("lat_before_edge", 8'b0000_0001);
        tick();
        check_y("lat_sel111", 8'b1000_0000);

        // Half-select boundary 011 -> 100
        set_sel(3'b011);
        tick();
        check_y("half_sel011", 8'b0000_1000);
        set_sel(3'b100);
        tick();
        check_y("half_sel100", 8'b0001_0000);

        // Mid-operation reset pulse between edges
        set_sel(3'b110);
        tick();
        check_y("mid_pre_reset", 8'b0100_0000);
        #1 rst = 1'b1;
        #1;
        check_y("mid_reset_async", 8'h00);
        rst = 1'b0;
        #1;
        check_y("mid_released_no_edge", 8'h00);
        tick();
        check_y("mid_after_edge", 8'b0100_0000);

        // WIDTH=8 instance
        w_in = 8'hA5;
        set_sel(3'b010);
        tick();
        check_w("w8_sel010_a5", 64'h0000_0000_00A5_0000);
        check_y("w1_sel010", 8'b0000_0100);
        w_in = 8'h3C;
        set_sel(3'b111);
        tick();
        check_w("w8_sel111_3c", 64'h3C00_0000_0000_0000);
        w_in = 8'h00;
        tick();
        check_w("w8_in_zero", 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1x8_using_1x4.md
Name: demux1x8_using_1x4

Overview:
- Registered 1-to-8 demultiplexer.
- A 3-bit select {s2,s1,s0} routes data input `in` to exactly one of outputs y0..y7; all other outputs are driven 0.
- Decode is structural: two 1x4 demux sub-blocks share s1/s0; s2 steers `in` to the lower (y0..y3) or upper (y4..y7) half.
- The outputs are captured in a register stage clocked by `clk`. The block sits in datapath steering logic wherever a single source fans out to one of eight sinks.

Parameters:
- WIDTH, 1, bit width of `in` and of each output y0..y7.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- y0  output  WIDTH  registered output, selected when {s2,s1,s0}=3'b000
- y1  output  WIDTH  selected at 3'b001
- y2  output  WIDTH  selected at 3'b010
- y3  output  WIDTH  selected at 3'b011
- y4  output  WIDTH  selected at 3'b100
- y5  output  WIDTH  selected at 3'b101
- y6  output  WIDTH  selected at 3'b110
- y7  output  WIDTH  selected at 3'b111
- s2  input  1  select MSB (half select: 0 = y0..y3, 1 = y4..y7)
- s1  input  1  select middle bit
- s0  input  1  select LSB
- in  input  WIDTH  data to route

Behaviour:
- One clock (`clk`), rising edge. Reset `rst` is asynchronous and active-high.
- While `rst`=1, y0..y7 = 0 immediately, independent of `clk`. Reset takes effect mid-operation on assertion.
- On the first rising edge after `rst` deasserts, outputs load normally.
- Combinational decode:
  - Lower 1x4 sub-block gets input `in & ~s2`; upper sub-block gets `in & s2` (bitwise across WIDTH).
  - Each sub-block drives output index {s1,s0} with its input and its other three outputs with 0.
  - Result: y[k] = in when k == {s2,s1,s0}, else 0.
- Register stage: on each rising edge of `clk` with `rst`=0, all eight output registers load their decoded values.
  - Latency is exactly 1 clock from select/data change to output.
  - There is no enable; outputs update every cycle.
- At most one output is nonzero in any cycle.
- When `in`=0, all outputs are 0 regardless of select.
- A select change moves the data to the new output and clears the old one on the same edge; there is no glitch or overlap at the register outputs.
- X/Z on select is not defined behaviour; the bench drives only known values.
- The 1x4 sub-block is a separate module in the same file, with the same WIDTH parameter and purely combinational logic. The top module instantiates it twice.
- No other state, no handshake, no overflow conditions.

Test Plan:
- Reset: assert `rst`=1 with in=1, sel=3'b101 → y0..y7 all 0 without a clock edge. Deassert `rst` → after next rising edge, y5=1 and all others 0.
- Exhaustive sweep (WIDTH=1): for sel in 000..111, apply in=0 for 1 cycle then in=1 for 1 cycle.
  - In each in=0 cycle, all outputs = 0.
  - In each in=1 cycle, only y[sel]=1 one clock later. Example: sel=3'b011, in=1 → y3=1, all others 0.
- Latency: change sel from 3'b000 to 3'b111 with in=1 held.
  - Outputs are unchanged until the next rising edge.
  - After that edge, y0=0 and y7=1 together.
- Half-select boundary: sel=3'b011 then 3'b100 with in=1 → y3=1, then y3=0 and y4=1; the upper/lower sub-block handoff is verified.
- Mid-operation reset: with y6=1 (sel=3'b110, in=1), pulse `rst` between clock edges → y6 drops to 0 asynchronously. It returns to 1 on the first edge after release.
- WIDTH=8: in=8'hA5, sel=3'b010 → y2=8'hA5, all other outputs 8'h00 after one clock.
